// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl: roll sequencer for the two-dice doubles game.
// A rising edge on roll tumbles both dice for SPIN_CYCLES cycles, holds them
// for the external equality comparator, samples its match result and updates
// the doubles score; reaching WIN_SCORE doubles latches win until reset.
module dice_roll_ctrl #(
  parameter int unsigned FACES       = 6,
  parameter int unsigned SPIN_CYCLES = 16,
  parameter int unsigned WIN_SCORE   = 3,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll,
  input  logic       match,
  output logic [3:0] die_a,
  output logic [3:0] die_b,
  output logic       busy,
  output logic       result_valid,
  output logic       doubles,
  output logic [3:0] score,
  output logic [7:0] rolls,
  output logic       win
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPIN   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    WON    = 3'd4
  } state_t;

  localparam logic [3:0] FACES_L   = 4'(FACES);
  localparam logic [7:0] SPIN_INIT = 8'(SPIN_CYCLES - 1);
  localparam logic [4:0] WIN_L     = 5'(WIN_SCORE);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic       roll_q, roll_d;
  logic [3:0] die_a_q, die_a_d;
  logic [3:0] die_b_q, die_b_d;
  logic [7:0] spin_cnt_q, spin_cnt_d;
  logic [7:0] rolls_q, rolls_d;
  logic [3:0] score_q, score_d;
  logic       doubles_q, doubles_d;
  logic       win_q, win_d;
  logic       result_valid_q, result_valid_d;
  logic       roll_edge;
  logic [4:0] score_inc;

  // Saturating counters: score stops at 15, accepted rolls stop at 255.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Die advance wraps FACES back to 1, so a die never leaves 1..FACES.
  function automatic logic [3:0] die_next(input logic [3:0] v);
    return (v == FACES_L) ? 4'd1 : v + 4'd1;
  endfunction

  assign roll_edge = roll & ~roll_q;
  assign score_inc = {1'b0, score_q} + 5'd1;

  // Next-state and datapath updates; the LFSR free-runs in every state.
  always_comb begin
    state_d        = state_q;
    lfsr_d         = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    roll_d         = roll;
    die_a_d        = die_a_q;
    die_b_d        = die_b_q;
    spin_cnt_d     = spin_cnt_q;
    rolls_d        = rolls_q;
    score_d        = score_q;
    doubles_d      = doubles_q;
    win_d          = win_q;
    result_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (roll_edge && !win_q) begin
          state_d    = SPIN;
          spin_cnt_d = SPIN_INIT;
          rolls_d    = sat_inc8(rolls_q);
        end
      end
      SPIN: begin
        die_a_d = die_next(die_a_q);
        if (lfsr_q[0]) die_b_d = die_next(die_b_q);
        if (spin_cnt_q == 8'd0) state_d = SETTLE;
        else                    spin_cnt_d = spin_cnt_q - 8'd1;
      end
      SETTLE: state_d = CHECK;
      CHECK: begin
        result_valid_d = 1'b1;
        doubles_d      = match;
        state_d        = IDLE;
        if (match) begin
          score_d = sat_inc4(score_q);
          if (score_inc >= WIN_L) begin
            state_d = WON;
            win_d   = 1'b1;
          end
        end
      end
      WON:     state_d = WON;
      default: state_d = IDLE;
    endcase
  end

  // State register; synchronous active-low reset wins in every state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      lfsr_q         <= LFSR_SEED;
      roll_q         <= 1'b1;
      die_a_q        <= 4'd1;
      die_b_q        <= 4'd1;
      spin_cnt_q     <= 8'd0;
      rolls_q        <= 8'd0;
      score_q        <= 4'd0;
      doubles_q      <= 1'b0;
      win_q          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      roll_q         <= roll_d;
      die_a_q        <= die_a_d;
      die_b_q        <= die_b_d;
      spin_cnt_q     <= spin_cnt_d;
      rolls_q        <= rolls_d;
      score_q        <= score_d;
      doubles_q      <= doubles_d;
      win_q          <= win_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = (state_q == SPIN) || (state_q == SETTLE) || (state_q == CHECK);
  assign die_a        = die_a_q;
  assign die_b        = die_b_q;
  assign result_valid = result_valid_q;
  assign doubles      = doubles_q;
  assign score        = score_q;
  assign rolls        = rolls_q;
  assign win          = win_q;

endmodule
